// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter and its neighbours:
// VGA timing generator, game-core write port, clear-engine control,
// frame-buffer BRAM port and the DAC pixel output.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 17
);
  // Timing generator side
  logic              valid;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;

  // Game-core write port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              wr_ready;

  // Screen-clear control
  logic              clr_start;
  logic [11:0]       clr_color;
  logic              clr_busy;
  logic              clr_done;

  // Frame-buffer BRAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_din;
  logic              ram_we;
  logic [11:0]       ram_dout;

  // Pixel to DAC pins
  logic [11:0]       pixel;

  // Arbiter view
  modport slave (
    input  valid, h_cnt, v_cnt,
    input  wr_req, wr_addr, wr_data,
    input  clr_start, clr_color,
    input  ram_dout,
    output wr_ready, clr_busy, clr_done,
    output ram_addr, ram_din, ram_we,
    output pixel
  );

  // Environment view (timing generator, game core, BRAM)
  modport master (
    output valid, h_cnt, v_cnt,
    output wr_req, wr_addr, wr_data,
    output clr_start, clr_color,
    output ram_dout,
    input  wr_ready, clr_busy, clr_done,
    input  ram_addr, ram_din, ram_we,
    input  pixel
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port 320x240x12 BRAM between the
// VGA display fetch and game-logic writers (through a small write FIFO),
// and optionally a screen-clear engine. Display reads take every even
// active column; every other cycle is a write slot. Each fetched word is
// shown for two pixels, giving a 2x upscale to 640x480 with 2 cycles of
// coordinate-to-pixel latency.
//
// Optional feature: define FB_CLR_EN to build the screen-clear engine.
// Without it, clr_busy/clr_done are tied low, clr_start/clr_color are
// ignored and every write slot serves the FIFO.
module vga_fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int ADDR_W     = 17
) (
  input logic             clk,
  input logic             rst,
  vga_fb_arbiter_if.slave bus
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 12;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  // ---------------------------------------------------------------------
  // Slot decode and display address
  // ---------------------------------------------------------------------
  logic              readSlot;
  logic [8:0]        hWord;
  logic [8:0]        vWord;
  logic [ADDR_W-1:0] readAddr;

  // Even active columns belong to the display; the odd ones and all of
  // blanking are free for writes. The word address is line*320 + column,
  // with the multiply by 320 split into two shifts (256 + 64).
  assign readSlot = bus.valid & ~bus.h_cnt[0];
  assign hWord    = bus.h_cnt[9:1];
  assign vWord    = bus.v_cnt[9:1];
  assign readAddr = ADDR_W'({vWord, 8'b0}) + ADDR_W'({vWord, 6'b0}) + ADDR_W'(hWord);

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  logic              clearing;
  logic [ADDR_W-1:0] clrAddr;
  logic [11:0]       clrColor;

`ifdef FB_CLR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_e;

  clrState_e         state_q, state_d;
  logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
  logic [11:0]       clrCol_q, clrCol_d;
  logic              clrDone_q, clrDone_d;

  // Clear FSM state, sweep address, latched colour and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clrAddr_q <= '0;
      clrCol_q  <= '0;
      clrDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clrAddr_q <= clrAddr_d;
      clrCol_q  <= clrCol_d;
      clrDone_q <= clrDone_d;
    end
  end

  // Next state: sweep one word per write slot, finish after the last word
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    clrCol_d  = clrCol_q;
    clrDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d   = CLEAR;
          clrAddr_d = '0;
          clrCol_d  = bus.clr_color;
        end
      end
      CLEAR: begin
        if (!readSlot) begin
          if (clrAddr_q == CLR_LAST) begin
            state_d   = IDLE;
            clrDone_d = 1'b1;
          end else begin
            clrAddr_d = clrAddr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clearing     = (state_q == CLEAR);
  assign clrAddr      = clrAddr_q;
  assign clrColor     = clrCol_q;
  assign bus.clr_busy = clearing;
  assign bus.clr_done = clrDone_q;
`else
  logic unusedClr;

  assign clearing     = 1'b0;
  assign clrAddr      = '0;
  assign clrColor     = '0;
  assign bus.clr_busy = 1'b0;
  assign bus.clr_done = 1'b0;
  assign unusedClr    = ^{bus.clr_start, bus.clr_color, CLR_LAST};
`endif

  // ---------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   fifoWrPtr_q;
  logic [PTR_W-1:0]   fifoRdPtr_q;
  logic [CNT_W-1:0]   fifoCount_q;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoPush;
  logic               fifoPop;
  logic [ENTRY_W-1:0] fifoHead;

  // The head is popped only on a write slot the clear engine is not using,
  // so queued writes wait behind a clear rather than interleaving with it.
  assign fifoFull  = (fifoCount_q == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCount_q == '0);
  assign fifoPush  = bus.wr_req & ~fifoFull;
  assign fifoPop   = ~rst & ~readSlot & ~clearing & ~fifoEmpty;
  assign fifoHead  = fifoMem_q[fifoRdPtr_q];

  assign bus.wr_ready = ~fifoFull;

  // FIFO pointers and occupancy; storage is written only on accepted pushes
  always_ff @(posedge clk) begin
    if (rst) begin
      fifoWrPtr_q <= '0;
      fifoRdPtr_q <= '0;
      fifoCount_q <= '0;
    end else begin
      if (fifoPush) begin
        fifoMem_q[fifoWrPtr_q] <= {bus.wr_addr, bus.wr_data};
        fifoWrPtr_q            <= fifoWrPtr_q + PTR_W'(1);
      end
      if (fifoPop) begin
        fifoRdPtr_q <= fifoRdPtr_q + PTR_W'(1);
      end
      case ({fifoPush, fifoPop})
        2'b10:   fifoCount_q <= fifoCount_q + CNT_W'(1);
        2'b01:   fifoCount_q <= fifoCount_q - CNT_W'(1);
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // BRAM port mux
  // ---------------------------------------------------------------------
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [11:0]       ramDin;

  // Display read first, then the clear sweep, then the FIFO head; the port
  // is parked at address 0 with writes disabled when idle or in reset.
  always_comb begin
    ramWe   = 1'b0;
    ramAddr = '0;
    ramDin  = '0;
    if (!rst) begin
      if (readSlot) begin
        ramAddr = readAddr;
      end else if (clearing) begin
        ramWe   = 1'b1;
        ramAddr = clrAddr;
        ramDin  = clrColor;
      end else if (!fifoEmpty) begin
        ramWe   = 1'b1;
        ramAddr = fifoHead[ENTRY_W-1:12];
        ramDin  = fifoHead[11:0];
      end
    end
  end

  assign bus.ram_we   = ramWe;
  assign bus.ram_addr = ramAddr;
  assign bus.ram_din  = ramDin;

  // ---------------------------------------------------------------------
  // Display read pipeline
  // ---------------------------------------------------------------------
  logic        rdPend_q;
  logic [11:0] pixHold_q;
  logic        validD1_q;
  logic        validD2_q;

  // Capture read data one cycle after the read slot and hold it across the
  // following column; valid is delayed to line up with the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPend_q  <= 1'b0;
      pixHold_q <= '0;
      validD1_q <= 1'b0;
      validD2_q <= 1'b0;
    end else begin
      rdPend_q  <= readSlot;
      if (rdPend_q) begin
        pixHold_q <= bus.ram_dout;
      end
      validD1_q <= bus.valid;
      validD2_q <= validD1_q;
    end
  end

  assign bus.pixel = validD2_q ? pixHold_q : 12'h000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: a behavioural BRAM with 1-cycle read
// latency, a table of hand-computed vectors for reads, pixel timing and
// single writes, and model-checked sequences for FIFO back-pressure, the
// screen clear (when FB_CLR_EN is defined) and reset during activity.
module tb_vga_fb_arbiter;

  localparam int ADDR_W     = 17;
  localparam int FIFO_DEPTH = 4;
  localparam int FB_W       = 320;
  localparam int FB_H       = 240;
  localparam int FB_WORDS   = FB_W * FB_H;

  logic clk = 1'b0;
  logic rst;
  logic rstNext;

  int testsRun    = 0;
  int testsFailed = 0;

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) fbIf ();

  vga_fb_arbiter #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FB_W      (FB_W),
    .FB_H      (FB_H),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fbIf)
  );

  // Frame-buffer BRAM: read-first, registered output
  logic [11:0] fbMem [FB_WORDS];

  always @(posedge clk) begin
    if (int'(fbIf.ram_addr) < FB_WORDS) begin
      fbIf.ram_dout <= fbMem[int'(fbIf.ram_addr)];
      if (fbIf.ram_we) fbMem[int'(fbIf.ram_addr)] <= fbIf.ram_din;
    end else begin
      fbIf.ram_dout <= 12'h000;
    end
  end

  // Reference model state
  logic [28:0] refQ[$];
  bit          refClear;
  int          refClrAddr;
  logic [11:0] refClrColor;
  bit          refDone;
  int          seenDone;

  typedef struct {
    logic        valid;
    int          h;
    int          v;
    logic        req;
    logic [16:0] addr;
    logic [11:0] data;
    logic        expWe;
    logic [16:0] expAddr;
    logic [11:0] expDin;
    logic        expReady;
    logic [11:0] expPixel;
  } vecRec_t;

  vecRec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, settle, return
  task automatic applyStimulus(input logic v, input int h, input int vc,
                               input logic req, input logic [16:0] a,
                               input logic [11:0] d, input logic cs,
                               input logic [11:0] cc);
    @(negedge clk);
    rst            = rstNext;
    fbIf.valid     = v;
    fbIf.h_cnt     = 10'(h);
    fbIf.v_cnt     = 10'(vc);
    fbIf.wr_req    = req;
    fbIf.wr_addr   = a;
    fbIf.wr_data   = d;
    fbIf.clr_start = cs;
    fbIf.clr_color = cc;
    #1;
  endtask

  // One cycle checked against the reference model, which then advances
  task automatic runModelCycle(input logic v, input int h, input int vc,
                               input logic req, input logic [16:0] a,
                               input logic [11:0] d, input logic cs,
                               input logic [11:0] cc, output bit accepted);
    bit          readSlot;
    bit          wasClear;
    bit          doneNext;
    logic        expWe;
    logic [16:0] expAddr;
    logic [11:0] expDin;
    logic        expReady;
    logic [32:0] act;
    logic [32:0] expv;
    applyStimulus(v, h, vc, req, a, d, cs, cc);
    readSlot = v && (h % 2 == 0);
    expWe    = 1'b0;
    expAddr  = '0;
    expDin   = '0;
    if (readSlot) begin
      expAddr = 17'((vc / 2) * 320 + h / 2);
    end else if (refClear) begin
      expWe   = 1'b1;
      expAddr = 17'(refClrAddr);
      expDin  = refClrColor;
    end else if (refQ.size() > 0) begin
      expWe   = 1'b1;
      expAddr = refQ[0][28:12];
      expDin  = refQ[0][11:0];
    end
    expReady = (refQ.size() < FIFO_DEPTH);
    act  = {fbIf.ram_we, fbIf.ram_addr, (expWe ? fbIf.ram_din : 12'h000),
            fbIf.wr_ready, fbIf.clr_busy, fbIf.clr_done};
    expv = {expWe, expAddr, expDin, expReady, refClear, refDone};
    checkOutput($sformatf("cycle{we,addr,din,rdy,busy,done} h=%0d v=%0d", h, vc),
                64'(act), 64'(expv));
    if (fbIf.clr_done === 1'b1) seenDone++;

    accepted = req && expReady;
    wasClear = refClear;
    doneNext = 1'b0;
    if (!readSlot && !wasClear && refQ.size() > 0) void'(refQ.pop_front());
    if (accepted) refQ.push_back({a, d});
    if (!readSlot && wasClear) begin
      if (refClrAddr == FB_WORDS - 1) begin
        refClear = 1'b0;
        doneNext = 1'b1;
      end else begin
        refClrAddr++;
      end
    end
`ifdef FB_CLR_EN
    if (!wasClear && cs) begin
      refClear    = 1'b1;
      refClrAddr  = 0;
      refClrColor = cc;
    end
`endif
    refDone = doneNext;
  endtask

  initial begin
    bit          acc;
    bit          sawStall;
    logic        vIn;
    int          hIn;
    logic        csIn;
    logic [11:0] ccIn;
    logic        reqIn;
    int          wIdx;
    int          pend;
    int          clrWrites;

    for (int i = 0; i < FB_WORDS; i++) fbMem[i] = 12'h000;
    fbMem[0]   = 12'h0F0;
    fbMem[1]   = 12'h321;
    fbMem[2]   = 12'h456;
    fbMem[370] = 12'h370;

    //          valid h    v    req addr   data    we addr    din     rdy pixel
    vecs[0]  = '{1'b1, 0,   0,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h000};
    vecs[1]  = '{1'b1, 1,   0,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h000};
    vecs[2]  = '{1'b1, 2,   0,   0, 17'd0, 12'h000, 0, 17'd1,     12'h000, 1, 12'h0F0};
    vecs[3]  = '{1'b1, 3,   0,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h0F0};
    vecs[4]  = '{1'b1, 4,   0,   0, 17'd0, 12'h000, 0, 17'd2,     12'h000, 1, 12'h321};
    vecs[5]  = '{1'b1, 5,   0,   1, 17'd5, 12'hABC, 0, 17'd0,     12'h000, 1, 12'h321};
    vecs[6]  = '{1'b1, 100, 3,   0, 17'd0, 12'h000, 0, 17'd370,   12'h000, 1, 12'h456};
    vecs[7]  = '{1'b1, 101, 3,   0, 17'd0, 12'h000, 1, 17'd5,     12'hABC, 1, 12'h456};
    vecs[8]  = '{1'b0, 102, 3,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h370};
    vecs[9]  = '{1'b0, 103, 3,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h370};
    vecs[10] = '{1'b0, 104, 3,   0, 17'd0, 12'h000, 0, 17'd0,     12'h000, 1, 12'h000};
    vecs[11] = '{1'b0, 105, 3,   1, 17'd7, 12'h777, 0, 17'd0,     12'h000, 1, 12'h000};
    vecs[12] = '{1'b0, 106, 3,   0, 17'd0, 12'h000, 1, 17'd7,     12'h777, 1, 12'h000};
    vecs[13] = '{1'b1, 2,   479, 0, 17'd0, 12'h000, 0, 17'd76481, 12'h000, 1, 12'h000};

    refQ.delete();
    refClear    = 1'b0;
    refClrAddr  = 0;
    refClrColor = 12'h000;
    refDone     = 1'b0;
    seenDone    = 0;

    // Reset with a would-be read slot on the inputs
    rstNext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 6, 1'b0, 17'd0, 12'h000, 1'b0, 12'h000);
      checkOutput("rst_ram_we", fbIf.ram_we, 0);
      checkOutput("rst_ram_addr", fbIf.ram_addr, 0);
      if (i > 0) begin
        checkOutput("rst_wr_ready", fbIf.wr_ready, 1);
        checkOutput("rst_pixel", fbIf.pixel, 0);
        checkOutput("rst_clr_busy", fbIf.clr_busy, 0);
        checkOutput("rst_clr_done", fbIf.clr_done, 0);
      end
    end
    rstNext = 1'b0;

    // Table: read addressing, pixel latency/doubling, single writes
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].h, vecs[i].v, vecs[i].req,
                    vecs[i].addr, vecs[i].data, 1'b0, 12'h000);
      checkOutput($sformatf("vec%0d_ram_we", i), fbIf.ram_we, vecs[i].expWe);
      checkOutput($sformatf("vec%0d_ram_addr", i), fbIf.ram_addr, vecs[i].expAddr);
      if (vecs[i].expWe)
        checkOutput($sformatf("vec%0d_ram_din", i), fbIf.ram_din, vecs[i].expDin);
      checkOutput($sformatf("vec%0d_wr_ready", i), fbIf.wr_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_pixel", i), fbIf.pixel, vecs[i].expPixel);
      checkOutput($sformatf("vec%0d_clr_busy", i), fbIf.clr_busy, 0);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 17'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("mem5_written", fbMem[5], 12'hABC);
    checkOutput("mem7_written", fbMem[7], 12'h777);

    // Back-to-back writes during active video: FIFO fills, requester holds
    wIdx     = 0;
    sawStall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      reqIn = (wIdx < 8);
      runModelCycle(c < 24, c, 10, reqIn, 17'(100 + wIdx), 12'(12'hB00 + wIdx),
                    1'b0, 12'h000, acc);
      if (reqIn && fbIf.wr_ready === 1'b0) sawStall = 1'b1;
      if (acc) wIdx++;
    end
    checkOutput("burst_all_pushed", wIdx, 8);
    checkOutput("burst_ready_dropped", sawStall, 1);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("burst_mem%0d", 100 + i), fbMem[100 + i], 12'(12'hB00 + i));

`ifdef FB_CLR_EN
    // Full clear in blanking with a short active burst, queued writes and a
    // second clr_start that must be ignored
    pend      = 0;
    clrWrites = 0;
    seenDone  = 0;
    for (int c = 0; c < 76830; c++) begin
      vIn   = (c >= 200 && c < 210);
      hIn   = vIn ? c - 200 : 0;
      csIn  = (c == 0) || (c == 1000);
      ccIn  = (c == 0) ? 12'h00F : 12'hF00;
      reqIn = (c >= 2) && (pend < 3);
      runModelCycle(vIn, hIn, 0, reqIn, 17'(10 + pend), 12'(12'hA01 + pend),
                    csIn, ccIn, acc);
      if (fbIf.ram_we === 1'b1 && fbIf.ram_din === 12'h00F) clrWrites++;
      if (acc) pend++;
    end
    checkOutput("clear_write_count", clrWrites, FB_WORDS);
    checkOutput("clear_done_pulses", seenDone, 1);
    checkOutput("clear_busy_after", fbIf.clr_busy, 0);
    checkOutput("clear_mem0", fbMem[0], 12'h00F);
    checkOutput("clear_mem5", fbMem[5], 12'h00F);
    checkOutput("clear_mem38400", fbMem[38400], 12'h00F);
    checkOutput("clear_mem76799", fbMem[76799], 12'h00F);
    checkOutput("clear_fifo_mem10", fbMem[10], 12'hA01);
    checkOutput("clear_fifo_mem11", fbMem[11], 12'hA02);
    checkOutput("clear_fifo_mem12", fbMem[12], 12'hA03);
`endif

    // Start a clear, queue writes, then reset in the middle of it
    pend = 0;
    for (int c = 0; c < 21; c++) begin
      csIn  = (c == 0);
      reqIn = (c >= 5) && (pend < 2);
      runModelCycle(1'b0, 0, 0, reqIn, 17'(20 + pend), 12'(12'hC01 + pend),
                    csIn, 12'h0F0, acc);
      if (acc) pend++;
    end
    rstNext = 1'b1;
    applyStimulus(1'b1, 0, 3, 1'b0, 17'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("rst_mid_ram_we", fbIf.ram_we, 0);
    checkOutput("rst_mid_ram_addr", fbIf.ram_addr, 0);
    refQ.delete();
    refClear = 1'b0;
    refDone  = 1'b0;
    rstNext  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      runModelCycle(1'b0, 0, 0, 1'b0, 17'd0, 12'h000, 1'b0, 12'h000, acc);
      if (c == 0) checkOutput("rst_mid_pixel", fbIf.pixel, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
